// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM 4:1 mux / 1:4 demux pair.
// Holds the channel count, slot index width, slot and lock-state encodings,
// and a small slot arithmetic helper.
package tdm_pkg;

  localparam int NCH    = 4;
  localparam int SLOT_W = 2;

  // Slot index carried on the TDM stream; also the mux-side select encoding.
  typedef enum logic [SLOT_W-1:0] {
    SLOT_A = 2'd0,
    SLOT_B = 2'd1,
    SLOT_C = 2'd2,
    SLOT_D = 2'd3
  } slot_e;

  // Frame alignment state of the receiver.
  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;

  // Next slot index, wrapping from the last channel back to channel a.
  function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] slot);
    return slot + {{(SLOT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage : tdm_pkg

// File: rtl/tdm_slot_ctr.sv
// Slot counter for the TDM demux.
// Priority: clear to 0 (hunting / dropped beat), load to 1 (beat captured
// as slot 0 on sync), advance with wrap on an accepted beat, else hold.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_load1,
  input  logic              i_adv,
  output logic [SLOT_W-1:0] o_slot
);

  logic [SLOT_W-1:0] r_slot;

  // Slot counter register; the counter naturally wraps 3 -> 0.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its inputs, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= SLOT_A;
    end else if (i_clr) begin
      r_slot <= SLOT_A;
    end else if (i_load1) begin
      r_slot <= SLOT_B;
    end else if (i_adv) begin
      r_slot <= slot_inc(r_slot);
    end
  end

  assign o_slot = r_slot;

endmodule : tdm_slot_ctr

// File: rtl/tdm_demux14.sv
// TDM 1:4 demultiplexer: receive-side counterpart of the 4:1 channel mux.
// Beats arrive in slot order a, b, c, d with sync marking slot 0. A lock FSM
// and slot counter steer each beat into a shadow register; all four outputs
// load together on the slot-3 beat so downstream never sees a torn frame.
// Optional build macro: TDM_DEMUX_STRICT_SYNC_EN -- a slot-0 beat without
// sync while locked is an error that drops the beat and returns to HUNT.
// Without it, a missing sync at slot 0 is tolerated (flywheel).
module tdm_demux14
  import tdm_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         sync,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic [W-1:0] d,
  output logic         s1,
  output logic         s2,
  output logic         frame_valid,
  output logic         locked,
  output logic         sync_err
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [SLOT_W-1:0] w_slot;

  logic              w_ctr_clr;
  logic              w_ctr_load1;
  logic              w_ctr_adv;
  logic              w_wr_en;
  slot_e             w_wr_slot;
  logic              w_frame_done;
  logic              w_err;

  // Shadow registers for slots a..c. The slot-3 beat goes straight from din
  // into output d, so it never needs a shadow copy.
  logic [W-1:0]      r_sh_a;
  logic [W-1:0]      r_sh_b;
  logic [W-1:0]      r_sh_c;

  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic [W-1:0]      r_c;
  logic [W-1:0]      r_d;
  logic              r_frame_valid;
  logic              r_sync_err;

  tdm_slot_ctr u_slot_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_ctr_clr),
    .i_load1 (w_ctr_load1),
    .i_adv   (w_ctr_adv),
    .o_slot  (w_slot)
  );

  // Lock FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-beat steering: which shadow to write, counter action,
  // frame completion and sync error.
  // NOTE: every signal gets a default before the case so no path leaves a
  // combinational output unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_ctr_clr    = 1'b0;
    w_ctr_load1  = 1'b0;
    w_ctr_adv    = 1'b0;
    w_wr_en      = 1'b0;
    w_wr_slot    = SLOT_A;
    w_frame_done = 1'b0;
    w_err        = 1'b0;

    case (r_state)
      HUNT: begin
        if (din_valid && sync) begin
          // Frame start found: this beat is slot 0.
          w_ctr_load1 = 1'b1;
          w_wr_en     = 1'b1;
          w_wr_slot   = SLOT_A;
          w_state_nxt = LOCK;
        end else begin
          // Unaligned beats are dropped; counter pinned at slot 0.
          w_ctr_clr   = 1'b1;
        end
      end

      LOCK: begin
        if (din_valid) begin
          if (sync && (w_slot != SLOT_A)) begin
            // Early sync: abandon the partial frame and restart on this beat.
            w_err       = 1'b1;
            w_ctr_load1 = 1'b1;
            w_wr_en     = 1'b1;
            w_wr_slot   = SLOT_A;
`ifdef TDM_DEMUX_STRICT_SYNC_EN
          end else if (!sync && (w_slot == SLOT_A)) begin
            // Missing sync at a frame boundary: alignment is suspect, re-hunt.
            w_err       = 1'b1;
            w_ctr_clr   = 1'b1;
            w_state_nxt = HUNT;
`endif
          end else begin
            // In-order beat for the expected slot.
            w_ctr_adv    = 1'b1;
            w_wr_en      = 1'b1;
            w_wr_slot    = slot_e'(w_slot);
            w_frame_done = (w_slot == SLOT_D);
          end
        end
      end

      default: begin
        w_state_nxt = HUNT;
        w_ctr_clr   = 1'b1;
      end
    endcase
  end

  // Shadow capture of slots a..c as their beats arrive.
  // NOTE: the shadow registers are reset along with everything else so a
  // frame after reset never exposes stale data from before it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_a <= '0;
      r_sh_b <= '0;
      r_sh_c <= '0;
    end else if (w_wr_en) begin
      case (w_wr_slot)
        SLOT_A:  r_sh_a <= din;
        SLOT_B:  r_sh_b <= din;
        SLOT_C:  r_sh_c <= din;
        default: ;
      endcase
    end
  end

  // Coherent output update: all four channels load on the slot-3 beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
      r_d <= '0;
    end else if (w_frame_done) begin
      r_a <= r_sh_a;
      r_b <= r_sh_b;
      r_c <= r_sh_c;
      r_d <= din;
    end
  end

  // Single-cycle status pulses aligned with the output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_frame_valid <= w_frame_done;
      r_sync_err    <= w_err;
    end
  end

  assign a           = r_a;
  assign b           = r_b;
  assign c           = r_c;
  assign d           = r_d;
  assign s1          = w_slot[1];
  assign s2          = w_slot[0];
  assign frame_valid = r_frame_valid;
  assign sync_err    = r_sync_err;
  assign locked      = (r_state == LOCK);

endmodule : tdm_demux14

// File: tb/tb_tdm_demux14.sv
// Directed bench for tdm_demux14: a W=8 instance driven from a vector table
// plus hand-written reset sequences, and a W=1 instance fed bit 0 of the same
// stream. Expectations follow TDM_DEMUX_STRICT_SYNC_EN when it is defined.
module tb_tdm_demux14;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       sync;

  logic [7:0] a, b, c, d;
  logic       s1, s2, frame_valid, locked, sync_err;

  logic [0:0] din1;
  logic [0:0] a1, b1, c1, d1;
  logic       s1_1, s2_1, fv_1, lk_1, err_1;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic       v;
    logic       s;
    logic [7:0] d;
    logic [7:0] ea, eb, ec, ed;
    logic       efv, elk, eerr;
    logic [1:0] eslot;
  } vec_t;

  vec_t tbl[$];

  tdm_demux14 #(.W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync(sync),
    .a(a), .b(b), .c(c), .d(d), .s1(s1), .s2(s2),
    .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err)
  );

  assign din1 = din[0];

  tdm_demux14 #(.W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .din_valid(din_valid), .sync(sync),
    .a(a1), .b(b1), .c(c1), .d(d1), .s1(s1_1), .s2(s2_1),
    .frame_valid(fv_1), .locked(lk_1), .sync_err(err_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: inputs change 1 time unit after a rising edge, outputs are
  // sampled 1 time unit after the following edge.
  task automatic cyc(input logic v, input logic s, input logic [7:0] dv);
    din       = dv;
    din_valid = v;
    sync      = s;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, input logic s, input logic [7:0] dv,
                     input logic [7:0] ea, input logic [7:0] eb,
                     input logic [7:0] ec, input logic [7:0] ed,
                     input logic efv, input logic elk, input logic eerr,
                     input logic [1:0] eslot);
    vec_t t;
    t.v = v; t.s = s; t.d = dv;
    t.ea = ea; t.eb = eb; t.ec = ec; t.ed = ed;
    t.efv = efv; t.elk = elk; t.eerr = eerr; t.eslot = eslot;
    tbl.push_back(t);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_outputs", {a, b, c, d}, 32'h0);
    check("rst_status", {locked, s1, s2, frame_valid, sync_err}, 32'h0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst_n     = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    sync      = 1'b0;

    //   v  s  din    a      b      c      d     fv lk er slot
    // Lock and first frame (values fit W=1 too).
    add(1, 1, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 2'd1);
    add(1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 2'd2);
    add(1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 0, 2'd3);
    add(1, 0, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 1, 1, 0, 2'd0);
    add(0, 0, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 0, 1, 0, 2'd0);
    // Frame 11..44.
    add(1, 1, 8'h11, 8'h01, 8'h00, 8'h00, 8'h00, 0, 1, 0, 2'd1);
    add(1, 0, 8'h22, 8'h01, 8'h00, 8'h00, 8'h00, 0, 1, 0, 2'd2);
    add(1, 0, 8'h33, 8'h01, 8'h00, 8'h00, 8'h00, 0, 1, 0, 2'd3);
    add(1, 0, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44, 1, 1, 0, 2'd0);
    // Frame A1..D4 with two idle cycles after B2: outputs hold until D4.
    add(1, 1, 8'hA1, 8'h11, 8'h22, 8'h33, 8'h44, 0, 1, 0, 2'd1);
    add(1, 0, 8'hB2, 8'h11, 8'h22, 8'h33, 8'h44, 0, 1, 0, 2'd2);
    add(0, 0, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 0, 1, 0, 2'd2);
    add(0, 1, 8'hEE, 8'h11, 8'h22, 8'h33, 8'h44, 0, 1, 0, 2'd2);
    add(1, 0, 8'hC3, 8'h11, 8'h22, 8'h33, 8'h44, 0, 1, 0, 2'd3);
    add(1, 0, 8'hD4, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 1, 1, 0, 2'd0);
    // Early sync after two beats: resync onto 55.
    add(1, 1, 8'hE1, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, 1, 0, 2'd1);
    add(1, 0, 8'hE2, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, 1, 0, 2'd2);
    add(1, 1, 8'h55, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, 1, 1, 2'd1);
    add(1, 0, 8'h66, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, 1, 0, 2'd2);
    add(1, 0, 8'h77, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, 1, 0, 2'd3);
    add(1, 0, 8'h88, 8'h55, 8'h66, 8'h77, 8'h88, 1, 1, 0, 2'd0);
    // Missing sync at a frame boundary.
`ifdef TDM_DEMUX_STRICT_SYNC_EN
    add(1, 0, 8'h91, 8'h55, 8'h66, 8'h77, 8'h88, 0, 0, 1, 2'd0);
    add(1, 0, 8'h92, 8'h55, 8'h66, 8'h77, 8'h88, 0, 0, 0, 2'd0);
    add(1, 0, 8'h93, 8'h55, 8'h66, 8'h77, 8'h88, 0, 0, 0, 2'd0);
    add(1, 0, 8'h94, 8'h55, 8'h66, 8'h77, 8'h88, 0, 0, 0, 2'd0);
`else
    add(1, 0, 8'h91, 8'h55, 8'h66, 8'h77, 8'h88, 0, 1, 0, 2'd1);
    add(1, 0, 8'h92, 8'h55, 8'h66, 8'h77, 8'h88, 0, 1, 0, 2'd2);
    add(1, 0, 8'h93, 8'h55, 8'h66, 8'h77, 8'h88, 0, 1, 0, 2'd3);
    add(1, 0, 8'h94, 8'h91, 8'h92, 8'h93, 8'h94, 1, 1, 0, 2'd0);
`endif
    add(0, 0, 8'h00, tbl[tbl.size()-1].ea, tbl[tbl.size()-1].eb,
        tbl[tbl.size()-1].ec, tbl[tbl.size()-1].ed, 0,
        tbl[tbl.size()-1].elk, 0, 2'd0);

    @(posedge clk);
    #1;
    pulse_reset();

    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].s, tbl[i].d);
      check($sformatf("vec%0d_data", i), {a, b, c, d},
            {tbl[i].ea, tbl[i].eb, tbl[i].ec, tbl[i].ed});
      check($sformatf("vec%0d_status", i), {frame_valid, locked, sync_err, s1, s2},
            {tbl[i].efv, tbl[i].elk, tbl[i].eerr, tbl[i].eslot});
      check($sformatf("vec%0d_w1", i), {a1, b1, c1, d1, fv_1, lk_1, err_1, s1_1, s2_1},
            {tbl[i].ea[0], tbl[i].eb[0], tbl[i].ec[0], tbl[i].ed[0],
             tbl[i].efv, tbl[i].elk, tbl[i].eerr, tbl[i].eslot});
    end

    // Hunt discard: unsynced beats after reset are dropped.
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 8'h30 + 8'(i));
      check($sformatf("hunt%0d_status", i), {locked, s1, s2, frame_valid, sync_err}, 32'h0);
      check($sformatf("hunt%0d_data", i), {a, b, c, d}, 32'h0);
    end

    // Mid-frame reset after the slot-2 beat, then a clean frame decodes.
    cyc(1'b1, 1'b1, 8'h01);
    cyc(1'b1, 1'b0, 8'h02);
    cyc(1'b1, 1'b0, 8'h03);
    cyc(1'b1, 1'b0, 8'h04);
    check("pre_rst_frame", {a, b, c, d}, 32'h01020304);
    cyc(1'b1, 1'b1, 8'h10);
    cyc(1'b1, 1'b0, 8'h20);
    cyc(1'b1, 1'b0, 8'h30);
    check("pre_rst_slot", {locked, s1, s2}, 32'h7);
    din_valid = 1'b0;
    sync      = 1'b0;
    pulse_reset();
    cyc(1'b0, 1'b0, 8'h40);
    check("post_rst_idle", {locked, s1, s2, frame_valid}, 32'h0);
    cyc(1'b1, 1'b1, 8'hC1);
    cyc(1'b1, 1'b0, 8'hC2);
    cyc(1'b1, 1'b0, 8'hC3);
    check("post_rst_hold", {a, b, c, d}, 32'h0);
    cyc(1'b1, 1'b0, 8'hC4);
    check("post_rst_frame", {a, b, c, d}, 32'hC1C2C3C4);
    check("post_rst_fv", {frame_valid, locked, sync_err}, 32'h6);
    cyc(1'b0, 1'b0, 8'h00);
    check("post_rst_fv_drop", {frame_valid, sync_err}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_tdm_demux14

// File: doc/tdm_demux14.md
Name: tdm_demux14

Overview:
- Receive-side counterpart of the 4:1 channel mux: de-serialises a time-division-multiplexed stream back into four parallel channels a, b, c and d.
- Input beats arrive in slot order a, b, c, d; a sync flag marks slot 0 (channel a).
- A slot counter and a lock FSM route each beat into a shadow register.
- All four outputs update together once per complete frame, so downstream logic never sees a torn frame.

Parameters:
- W, 1, data width of each channel and of din.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  W  multiplexed data beat.
- din_valid  input  1  din/sync qualify this cycle; no backpressure.
- sync  input  1  beat is slot 0 (channel a); ignored when din_valid=0.
- a  output  W  channel 0 data, registered.
- b  output  W  channel 1 data, registered.
- c  output  W  channel 2 data, registered.
- d  output  W  channel 3 data, registered.
- s1  output  1  MSB of the next expected slot index.
- s2  output  1  LSB of the next expected slot index.
- frame_valid  output  1  one-cycle pulse when a, b, c, d update.
- locked  output  1  FSM is in LOCK.
- sync_err  output  1  one-cycle pulse on a sync/slot mismatch.

Behaviour:
- Reset: the asynchronous assert of rst_n forces all of the following immediately, regardless of clk:
  - a, b, c, d, all shadow registers, frame_valid, locked and sync_err go to 0.
  - The slot counter goes to 0 and the FSM goes to HUNT.
  - Any partial frame is discarded.
  - Reset deassertion is used directly; the upstream synchroniser is outside this block.
- Slot counter: 2 bits, exposed as {s1,s2}. It advances by 1 on each accepted beat and wraps 3→0.
- FSM HUNT:
  - Beats with sync=0 are dropped; the counter is held at 0.
  - A beat with din_valid=1 and sync=1 is captured as slot 0, the counter goes to 1, and the FSM moves to LOCK.
- FSM LOCK:
  - Each valid beat is written to the shadow register selected by {s1,s2}: 0→a, 1→b, 2→c, 3→d.
  - On the slot-3 beat, a/b/c/d load shadow a, b, c and din simultaneously at the same clock edge. frame_valid is high in the following cycle for exactly one cycle, so latency is 1 cycle from the slot-3 beat.
  - sync=1 on a beat while slot≠0:
    - sync_err pulses.
    - The partial frame is discarded; no frame_valid, and outputs hold.
    - The beat is captured as slot 0 and the counter is set to 1; the FSM stays in LOCK (fast resync).
  - sync=0 on a slot-0 beat:
    - Default build: accepted as slot 0 (flywheel).
    - Behaviour with the optional feature is given below.
- Outputs hold their last values between frames.
- Idle cycles (din_valid=0) are allowed anywhere, including mid-frame; they do not change state.
- locked = (state==LOCK), registered.

Optional Feature:
- Macro: TDM_DEMUX_STRICT_SYNC_EN.
- Defined:
  - A LOCK beat at slot 0 with sync=0 pulses sync_err, drops the beat and returns the FSM to HUNT.
  - The counter is held at 0; locked falls on the next cycle.
- Undefined: flywheel behaviour as described in Behaviour; sync is only checked for unexpected assertion.

Decomposition:
- Shared package tdm_pkg holds:
  - localparam NCH=4 and SLOT_W=2.
  - Slot enum: SLOT_A=0, SLOT_B=1, SLOT_C=2, SLOT_D=3.
  - State enum: HUNT, LOCK.
- The mux side reuses the same package for its select encoding.
- Natural sub-module: tdm_slot_ctr, holding the 2-bit counter with load-to-1 on sync, wrap, and hold in HUNT.
- Shadow registers, output registers and the FSM stay in the top level.

Test Plan:
- Lock and frame, W=1: pulse rst_n low, then 4 valid beats din=1,0,0,0 with sync on the first → a=1,b=0,c=0,d=0; frame_valid=1 one cycle after the 4th beat; locked=1; sync_err=0.
- Coherent update, W=8:
  - Frame 0x11,0x22,0x33,0x44, then frame 0xA1,0xB2,0xC3,0xD4 with 2 idle cycles inserted after 0xB2.
  - a..d stay at 0x11..0x44 until the 0xD4 beat, then all switch in the same cycle.
- Early sync: after 2 beats of a frame, a beat 0x55 with sync=1 → sync_err pulse, no frame_valid; after 3 more beats 0x66,0x77,0x88 → a..d=0x55,0x66,0x77,0x88.
- Hunt discard: after reset, 3 valid beats with sync=0 → locked stays 0, {s1,s2}=00, no frame_valid.
- Missing sync at a frame boundary:
  - Default build: the frame completes and frame_valid pulses.
  - With TDM_DEMUX_STRICT_SYNC_EN: sync_err pulses, locked=0, no frame_valid.
- Mid-frame reset: assert rst_n low between clock edges after the slot-2 beat → a..d, locked and {s1,s2} go to 0 immediately; the next sync-led frame decodes correctly.
